// File: rtl/display_pkg.sv
// Shared constants for the display read path: frame geometry and fetch FSM encoding.
package display_pkg;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 36;
  localparam int unsigned LAST_ADDR  = 3200;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO; simultaneous push and pop is allowed at any occupancy, including full.
module fetch_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves on the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_frame_fetch.sv
// Frame read sequencer: issues credit-limited reads to the frame RAM, captures its
// 1-cycle registered data and streams it out over valid/ready with a last-word flag.
module ram_frame_fetch #(
  parameter int unsigned ADDR_W     = display_pkg::ADDR_W,
  parameter int unsigned DATA_W     = display_pkg::DATA_W,
  parameter int unsigned LAST_ADDR  = display_pkg::LAST_ADDR,
  parameter int unsigned FIFO_DEPTH = display_pkg::FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  output logic              o_request,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_frame_done
);

  import display_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_inflight_last;

  logic              w_issue;
  logic              w_at_last;
  logic              w_valid;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W:0]   w_head;

  // Credit: words buffered plus the one in the RAM pipeline must leave room for another.
  assign w_at_last = (r_addr == ADDR_W'(LAST_ADDR));
  assign w_issue   = (r_state == ST_FETCH) &&
                     ((32'(w_count) + 32'(r_inflight)) < FIFO_DEPTH);

  assign w_valid = !w_fifo_empty;
  assign w_pop   = w_valid && i_ready;

  assign o_request    = w_issue;
  assign o_addr       = r_addr;
  assign o_valid      = w_valid;
  assign o_data       = w_head[DATA_W-1:0];
  assign o_last       = w_head[DATA_W];
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = w_pop && w_head[DATA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_issue && w_at_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (o_frame_done) w_state_nxt = i_continuous ? ST_FETCH : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Address counter wraps to 0 on the last issue, ready for a continuous restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else if (w_issue) begin
      r_addr <= w_at_last ? '0 : r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_at_last;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_inflight),
    .i_push_data ({r_inflight_last, i_mem_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count)
  );

  // RAM data arriving while the FIFO is full and not draining would be lost.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(r_inflight && w_fifo_full && !w_pop));
    end
  end

endmodule
